// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// uart_rx : 8-bit UART receiver, optional parity, 3-sample majority voting
// Rev 1.0
// ============================================================================
module uart_rx #(
  parameter int PRESCALE   = 8,
  parameter bit PARITY_EN  = 1'b1,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       S_DATA,
  output logic [7:0] P_DATA,
  output logic       Data_Valid,
  output logic       Parity_Error,
  output logic       Stop_Error,
  output logic       busy
);

  localparam int SW = $clog2(PRESCALE);
  localparam logic [SW-1:0] S_A    = SW'(PRESCALE / 2 - 1);
  localparam logic [SW-1:0] S_B    = SW'(PRESCALE / 2);
  localparam logic [SW-1:0] S_C    = SW'(PRESCALE / 2 + 1);
  localparam logic [SW-1:0] S_LAST = SW'(PRESCALE - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t        state;
  logic          rx_meta;
  logic          rx_s;
  logic [SW-1:0] s;
  logic [2:0]    idx;
  logic          samp_a;
  logic          samp_b;
  logic [7:0]    shreg;
  logic          par_bad;
  logic          stop_bad;
  logic          done;
  logic          wait_high;
  logic          maj;
  logic          par_exp;

  assign maj     = (samp_a & samp_b) | (samp_a & rx_s) | (samp_b & rx_s);
  assign par_exp = (^shreg) ^ PARITY_ODD;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= S_DATA;
      rx_s    <= rx_meta;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state        <= IDLE;
      s            <= '0;
      idx          <= '0;
      samp_a       <= 1'b0;
      samp_b       <= 1'b0;
      shreg        <= '0;
      par_bad      <= 1'b0;
      stop_bad     <= 1'b0;
      done         <= 1'b0;
      wait_high    <= 1'b0;
      P_DATA       <= '0;
      Data_Valid   <= 1'b0;
      Parity_Error <= 1'b0;
      Stop_Error   <= 1'b0;
      busy         <= 1'b0;
    end else begin
      // completion is reported one edge after the stop-bit decision
      busy         <= (state != IDLE);
      done         <= 1'b0;
      Data_Valid   <= done & ~par_bad & ~stop_bad;
      Parity_Error <= done & par_bad;
      Stop_Error   <= done & stop_bad;
      if (done && !par_bad && !stop_bad) P_DATA <= shreg;

      if (state != IDLE) begin
        if (s == S_A) samp_a <= rx_s;
        if (s == S_B) samp_b <= rx_s;
        s <= (s == S_LAST) ? '0 : s + 1'b1;
      end

      case (state)
        IDLE: begin
          s <= '0;
          // a stop error leaves the line suspect until it is seen high again
          if (wait_high) begin
            if (rx_s) wait_high <= 1'b0;
          end else if (!rx_s) begin
            state   <= START;
            s       <= SW'(1);
            par_bad <= 1'b0;
          end
        end
        START: begin
          if (s == S_C && maj) begin
            state <= IDLE;
            s     <= '0;
          end else if (s == S_LAST) begin
            state <= DATA;
            idx   <= '0;
          end
        end
        DATA: begin
          if (s == S_C) shreg[idx] <= maj;
          if (s == S_LAST) begin
            idx <= idx + 1'b1;
            if (idx == 3'd7) state <= PARITY_EN ? PARITY : STOP;
          end
        end
        PARITY: begin
          if (s == S_C) par_bad <= (maj != par_exp);
          if (s == S_LAST) state <= STOP;
        end
        STOP: begin
          if (s == S_C) begin
            state     <= IDLE;
            s         <= '0;
            done      <= 1'b1;
            stop_bad  <= ~maj;
            wait_high <= ~maj;
          end
        end
        default: begin
          state <= IDLE;
          s     <= '0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
